// File: rtl/pixel_scanner.sv
// pixel_scanner: raster-order pixel coordinate generator with valid/ready handshake and frame flags
module pixel_scanner #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   coords_ready,
  output logic [31:0]            screen_x,
  output logic [31:0]            screen_y,
  output logic                   coords_valid,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_count
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [15:0] X_MAX = 16'(SCREEN_WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(SCREEN_HEIGHT - 1);
  state_t state, state_n;
  logic [15:0] x, y, x_n, y_n, x_inc, y_inc;
  logic valid_n, sof_n, eol_n, eof_n, done_n, acc;
  logic [FRAME_CNT_W-1:0] fc_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      coords_valid <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      done         <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      coords_valid <= valid_n;
      sof          <= sof_n;
      eol          <= eol_n;
      eof          <= eof_n;
      done         <= done_n;
      frame_count  <= fc_n;
    end
  end
  assign acc   = coords_valid & coords_ready;
  assign x_inc = (x == X_MAX) ? 16'd0 : x + 16'd1;
  assign y_inc = (x == X_MAX) ? y + 16'd1 : y;
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    valid_n = coords_valid;
    sof_n   = sof;
    eol_n   = eol;
    eof_n   = eof;
    done_n  = 1'b0;
    fc_n    = frame_count;
    if (state == IDLE) begin
      if (start && !abort) begin
        state_n = SCAN;
        x_n     = '0;
        y_n     = '0;
        valid_n = 1'b1;
        sof_n   = 1'b1;
        eol_n   = 1'b0;
        eof_n   = 1'b0;
      end
    end else if (abort || (acc && eof)) begin
      // abort beats any accept, including the eof pixel's
      state_n = IDLE;
      valid_n = 1'b0;
      sof_n   = 1'b0;
      eol_n   = 1'b0;
      eof_n   = 1'b0;
      done_n  = !abort;
      fc_n    = abort ? frame_count : frame_count + FRAME_CNT_W'(1);
    end else if (acc) begin
      x_n   = x_inc;
      y_n   = y_inc;
      sof_n = 1'b0;
      eol_n = x_inc == X_MAX;
      eof_n = (x_inc == X_MAX) && (y_inc == Y_MAX);
    end
  end
  assign screen_x = {16'd0, x};
  assign screen_y = {16'd0, y};
  assign busy     = state == SCAN;
endmodule

// File: tb/tb_pixel_scanner.sv
// tb_pixel_scanner: vector table plus randomized frames checked against a raster-index model
module tb_pixel_scanner;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic coords_ready = 1'b0;
  logic [31:0] screen_x, screen_y;
  logic coords_valid, sof, eol, eof, busy, done;
  logic [15:0] frame_count;
  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;

  pixel_scanner #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .coords_ready(coords_ready),
    .screen_x(screen_x), .screen_y(screen_y), .coords_valid(coords_valid),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit s, a, r;
    bit v, b, d;
    int x, y;
    bit sf, el, ef;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs while pixel number idx of the raster is presented
  task automatic chk_px(input int idx);
    chk("valid", coords_valid, 1);
    chk("x", screen_x, idx % W);
    chk("y", screen_y, idx / W);
    chk("sof", sof, idx == 0);
    chk("eol", eol, (idx % W) == W - 1);
    chk("eof", eof, idx == N - 1);
    chk("busy", busy, 1);
    chk("done", done, 0);
  endtask

  task automatic chk_idle(input string tag, input bit exp_done);
    chk({tag, "_valid"}, coords_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_fc"}, frame_count, exp_fc);
  endtask

  task automatic frame(input int pct);
    int idx = 0;
    int cyc = 0;
    bit r;
    start = 1;
    abort = 0;
    coords_ready = 1'($urandom % 2);
    tick();
    start = 0;
    while (idx < N && cyc < 400) begin
      chk_px(idx);
      r = ($urandom % 100) < pct;
      coords_ready = r;
      start = ($urandom % 5) == 0;
      tick();
      if (r) idx++;
      cyc++;
    end
    start = 0;
    coords_ready = 0;
    chk("frame_pixels", idx, N);
    if (pct == 100) chk("throughput", cyc, N);
    exp_fc++;
    chk_idle("end", 1);
  endtask

  initial begin
    vec_t tbl[13] = '{
      '{1,0,1, 1,1,0, 0,0, 1,0,0},
      '{0,0,1, 1,1,0, 1,0, 0,0,0},
      '{0,0,0, 1,1,0, 1,0, 0,0,0},
      '{0,0,1, 1,1,0, 2,0, 0,0,0},
      '{0,0,1, 1,1,0, 3,0, 0,1,0},
      '{0,0,1, 1,1,0, 0,1, 0,0,0},
      '{0,0,1, 1,1,0, 1,1, 0,0,0},
      '{0,0,1, 1,1,0, 2,1, 0,0,0},
      '{0,1,1, 0,0,0, 0,0, 0,0,0},
      '{1,1,1, 0,0,0, 0,0, 0,0,0},
      '{1,0,0, 1,1,0, 0,0, 1,0,0},
      '{1,0,1, 1,1,0, 1,0, 0,0,0},
      '{0,1,0, 0,0,0, 0,0, 0,0,0}
    };
    #2;
    chk("rst_valid", coords_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_x", screen_x, 0);
    chk("rst_y", screen_y, 0);
    chk("rst_flags", {sof, eol, eof}, 0);
    tick();
    rst = 0;
    tick();
    chk_idle("post_rst", 0);
    // Abort on (2,1), start+abort in IDLE, restart, start ignored in SCAN
    foreach (tbl[i]) begin
      start = tbl[i].s;
      abort = tbl[i].a;
      coords_ready = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_valid", i), coords_valid, tbl[i].v);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].d);
      chk($sformatf("tbl%0d_fc", i), frame_count, exp_fc);
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_x", i), screen_x, tbl[i].x);
        chk($sformatf("tbl%0d_y", i), screen_y, tbl[i].y);
        chk($sformatf("tbl%0d_flags", i), {sof, eol, eof}, {tbl[i].sf, tbl[i].el, tbl[i].ef});
      end
    end
    start = 0;
    abort = 0;
    coords_ready = 0;
    tick();
    chk_idle("tbl_end", 0);
    frame(100);
    tick();
    chk_idle("gap", 0);
    for (int k = 0; k < 4; k++) begin
      frame(30 + 20 * k);
      tick();
      chk_idle("gap", 0);
    end
    // back-to-back frames: second start lands on the done cycle
    frame(70);
    frame(70);
    frame(100);
    tick();
    chk_idle("chain_end", 0);
    // abort coincident with the eof accept
    start = 1;
    coords_ready = 1;
    tick();
    start = 0;
    for (int k = 0; k < N - 1; k++) tick();
    chk_px(N - 1);
    abort = 1;
    tick();
    abort = 0;
    coords_ready = 0;
    chk_idle("eof_abort", 0);
    tick();
    chk_idle("eof_abort2", 0);
    // asynchronous reset between edges in mid-frame
    start = 1;
    coords_ready = 1;
    tick();
    start = 0;
    tick();
    tick();
    #3;
    rst = 1;
    #1;
    exp_fc = 0;
    chk("arst_valid", coords_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fc", frame_count, 0);
    chk("arst_x", screen_x, 0);
    chk("arst_y", screen_y, 0);
    chk("arst_flags", {sof, eol, eof}, 0);
    coords_ready = 0;
    @(negedge clk);
    rst = 0;
    tick();
    chk_idle("arst_after", 0);
    frame(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/pixel_scanner.md
Name: pixel_scanner

Overview:
- Upstream feeder for the ray generator stage.
- Walks every pixel of a frame in raster order (x fastest, then y).
- Presents integer screen coordinates with a valid/ready handshake, one pixel per cycle at full throughput.
- Raises frame-boundary flags, a done pulse and a frame counter, so the ray pipeline can be started, stalled and aborted by the frame controller.

Parameters:
- SCREEN_WIDTH, `SCREEN_WIDTH (640): pixels per line; legal range 2..65535.
- SCREEN_HEIGHT, `SCREEN_HEIGHT (480): lines per frame; legal range 2..65535.
- FRAME_CNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a frame; honoured only in IDLE.
- abort  in  1  synchronous cancel of the frame in progress.
- coords_ready  in  1  downstream can accept; tie high when the consumer never stalls.
- screen_x  out  32  fp-typed carrier, integer pixel column 0..SCREEN_WIDTH-1, zero-extended, not shifted (consumer shifts by FRAC_BITS).
- screen_y  out  32  fp-typed carrier, integer pixel row 0..SCREEN_HEIGHT-1, zero-extended.
- coords_valid  out  1  screen_x/screen_y hold a pixel.
- sof  out  1  qualifies the current pixel as (0,0).
- eol  out  1  qualifies the current pixel as x = SCREEN_WIDTH-1.
- eof  out  1  qualifies the current pixel as (SCREEN_WIDTH-1, SCREEN_HEIGHT-1).
- busy  out  1  state is SCAN.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- frame_count  out  FRAME_CNT_W  frames completed since reset.

Behaviour:
- Reset (async assert, outputs valid immediately): state IDLE. screen_x=0, screen_y=0, coords_valid=0, sof=0, eol=0, eof=0, busy=0, done=0, frame_count=0.
- States: IDLE and SCAN. "Accept" means coords_valid & coords_ready on a rising edge.
- IDLE, start=1, abort=0 at edge k:
  - After edge k: state SCAN, busy=1, coords_valid=1, (x,y)=(0,0), sof=1.
  - Latency from start to first pixel is one cycle.
- SCAN, no accept: screen_x, screen_y, sof, eol and eof hold exactly. The output register is stable under backpressure.
- SCAN, accept, pixel not eof:
  - Load the next raster pixel on the same edge (no bubble). Sustained throughput is 1 pixel/cycle while coords_ready=1.
  - If x < SCREEN_WIDTH-1: x <= x+1.
  - Else: x <= 0 and y <= y+1.
  - sof <= 0. eol and eof are recomputed from the new coordinates.
- SCAN, accept, pixel is eof:
  - coords_valid <= 0, state IDLE, busy <= 0.
  - done <= 1 for exactly one cycle.
  - frame_count <= frame_count+1, wrapping modulo 2^FRAME_CNT_W.
  - screen_x and screen_y keep their last value.
- abort=1 at any edge in SCAN:
  - coords_valid <= 0, state IDLE, busy <= 0, flags cleared.
  - No done pulse and no frame_count increment.
  - abort wins over a simultaneous accept, including an accept of the eof pixel.
- abort in IDLE: no effect. start together with abort: abort wins, no frame starts.
- start while in SCAN: ignored, no queuing.
- start on the cycle done is high: legal. The new frame begins and the first pixel appears the next cycle.
- Width rules: internal x and y counters are 16 bits, compared against SCREEN_WIDTH-1 and SCREEN_HEIGHT-1. No arithmetic beyond increment and compare.
- Async reset mid-frame: all outputs return to reset values at once, and any partial frame is discarded.
- Pixels per frame: exactly SCREEN_WIDTH*SCREEN_HEIGHT accepts between the start and the done pulse.

Test Plan (SCREEN_WIDTH=4, SCREEN_HEIGHT=3 unless stated):
1. Reset, then start pulse with coords_ready=1:
   - 12 consecutive accepts in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
   - sof only on the 1st, eol on the 4th/8th/12th, eof on the 12th.
   - done high the cycle after the 12th accept; frame_count=1.
2. Random coords_ready toggling:
   - Outputs stable whenever coords_valid=1 and coords_ready=0.
   - Still exactly 12 unique pixels in raster order, then done.
3. abort asserted on the edge where (2,1) would be accepted:
   - coords_valid=0 next cycle, no done, frame_count unchanged.
   - A following start restarts at (0,0).
4. Collisions:
   - start during SCAN is ignored.
   - start coincident with done launches a second frame; frame_count reaches 2.
   - start+abort in IDLE leaves busy=0.
5. Async rst asserted mid-frame between clock edges:
   - All outputs read reset values before the next edge.
6. Default parameters (640×480), coords_ready=1:
   - done exactly 307200 cycles after the first coords_valid.
   - Last pixel (639,479) carries eof.
